mux1h_dflt_pipe: RTL and testbench

Parametrised, pipelined one-hot multiplexer with default: selects one of N WIDTH-bit channels by a one-hot select vector, substitutes a default word when no select bit is set, and delivers the result through a registered valid/ready stage with a 2-entry skid buffer. It adds configurable multi-hot resolution and sticky multi-hot error reporting. It sits between datapath producers and a back-pressured consumer, replacing the fixed 8-input combinational one-hot mux where timing closure or flow control is needed.

---
 rtl/mux1h_pkg.sv | 39 +++
 rtl/mux1h_dflt_pipe_if.sv | 26 ++
 rtl/mux1h_skid.sv | 54 +++++
 rtl/mux1h_dflt_pipe.sv | 85 ++++++++
 tb/tb_mux1h_dflt_pipe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mux1h_pkg.sv
// Shared types and select-vector helpers for the pipelined one-hot mux with default.
package mux1h_pkg;

  typedef enum logic [1:0] {
    MH_OR,
    MH_PRIO,
    MH_DFLT
  } mh_mode_e;

  localparam int MAXN = 64;
  localparam int IDXW = 6;

  function automatic logic is_zero_hot(input logic [MAXN-1:0] v);
    return ~|v;
  endfunction

  // Carry a "seen a bit" flag along the vector: a second hit is a multi-hot.
  function automatic logic is_multi_hot(input logic [MAXN-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MAXN; i++) begin
      multi = multi | (seen & v[i]);
      seen  = seen | v[i];
    end
    return multi;
  endfunction

  function automatic logic [IDXW-1:0] lowest_set_index(input logic [MAXN-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = MAXN - 1; i >= 0; i--) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux1h_dflt_pipe_if.sv
// Transaction-in / result-out bundle of the pipelined one-hot mux.
interface mux1h_dflt_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic [WIDTH-1:0]     dflt;
  logic [N-1:0]         sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_hit;
  logic                 out_multi;

  modport master (
    output in_valid, in_data, dflt, sel, out_ready,
    input  in_ready, out_valid, out_data, out_hit, out_multi
  );

  modport slave (
    input  in_valid, in_data, dflt, sel, out_ready,
    output in_ready, out_valid, out_data, out_hit, out_multi
  );
endinterface

// File: rtl/mux1h_skid.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid slot,
// with in_ready driven purely from a flop.
module mux1h_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         or_valid, sk_valid;
  logic [W-1:0] or_data, sk_data;
  logic         accept, drain;

  assign in_ready  = !sk_valid;
  assign out_valid = or_valid;
  assign out_data  = or_data;
  assign accept    = in_valid && !sk_valid;
  assign drain     = or_valid && out_ready;

  // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
  // NOTE: payload flops are reset too, since the output word must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      or_data  <= '0;
      sk_data  <= '0;
    end else if (drain) begin
      // SK full implies in_ready was low, so no new word competes this cycle.
      if (sk_valid) begin
        or_data  <= sk_data;
        sk_valid <= 1'b0;
      end else if (accept) begin
        or_data  <= in_data;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (!or_valid) begin
      if (accept) begin
        or_data  <= in_data;
        or_valid <= 1'b1;
      end
    end else if (accept) begin
      sk_data  <= in_data;
      sk_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mux1h_dflt_pipe.sv
// One-hot mux with default word and configurable multi-hot resolution, registered
// through a skid buffer; also tracks multi-hot selects with a sticky flag and counter.
module mux1h_dflt_pipe
  import mux1h_pkg::*;
#(
  parameter int       WIDTH = 8,
  parameter int       N     = 8,
  parameter mh_mode_e MODE  = MH_OR,
  parameter int       CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux1h_dflt_pipe_if.slave    bus,
  input  logic                err_clr,
  output logic                err_sticky,
  output logic [CNTW-1:0]     err_cnt
);
  logic [MAXN-1:0]  sel_ext;
  logic [IDXW-1:0]  prio_idx;
  logic             zero_hot, multi_hot;
  logic [WIDTH-1:0] or_word, prio_word, res_word;
  logic [WIDTH+1:0] payload, out_payload;
  logic             accept, acc_multi;

  assign sel_ext   = MAXN'(bus.sel);
  assign zero_hot  = is_zero_hot(sel_ext);
  assign multi_hot = is_multi_hot(sel_ext);
  assign prio_idx  = lowest_set_index(sel_ext);

  // NOTE: combinational logic uses blocking assignments with a default first, so no latches.
  always_comb begin
    or_word   = '0;
    prio_word = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel[k]) or_word = or_word | bus.in_data[k*WIDTH +: WIDTH];
      if (prio_idx == IDXW'(k)) prio_word = bus.in_data[k*WIDTH +: WIDTH];
    end

    res_word = or_word;
    if (zero_hot) begin
      res_word = bus.dflt;
    end else if (multi_hot) begin
      case (MODE)
        MH_PRIO: res_word = prio_word;
        MH_DFLT: res_word = bus.dflt;
        default: res_word = or_word;
      endcase
    end
  end

  assign payload = {!zero_hot, multi_hot, res_word};

  mux1h_skid #(.W(WIDTH + 2)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign bus.out_hit   = out_payload[WIDTH+1];
  assign bus.out_multi = out_payload[WIDTH];
  assign bus.out_data  = out_payload[WIDTH-1:0];

  assign accept    = bus.in_valid && bus.in_ready;
  assign acc_multi = accept && multi_hot;

  // A clear coinciding with a multi-hot acceptance restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (err_clr) begin
      err_sticky <= acc_multi;
      err_cnt    <= acc_multi ? CNTW'(1) : '0;
    end else if (acc_multi) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mux1h_dflt_pipe.sv
// Directed bench: three instances (OR / PRIO / DFLT resolution) share one stimulus;
// the DFLT instance uses a 2-bit error counter to exercise saturation.
module tb_mux1h_dflt_pipe;
  import mux1h_pkg::*;

  localparam int WIDTH = 8;
  localparam int N     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic               err_clr = 1'b0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0]   dflt = '0;
  logic [N-1:0]       sel = '0;

  logic       sticky_o, sticky_p, sticky_d;
  logic [7:0] cnt_o, cnt_p;
  logic [1:0] cnt_d;

  mux1h_dflt_pipe_if #(.WIDTH(WIDTH), .N(N)) ifo ();
  mux1h_dflt_pipe_if #(.WIDTH(WIDTH), .N(N)) ifp ();
  mux1h_dflt_pipe_if #(.WIDTH(WIDTH), .N(N)) ifd ();

  assign ifo.in_valid = in_valid;  assign ifo.in_data = in_data;  assign ifo.dflt = dflt;
  assign ifo.sel = sel;            assign ifo.out_ready = out_ready;
  assign ifp.in_valid = in_valid;  assign ifp.in_data = in_data;  assign ifp.dflt = dflt;
  assign ifp.sel = sel;            assign ifp.out_ready = out_ready;
  assign ifd.in_valid = in_valid;  assign ifd.in_data = in_data;  assign ifd.dflt = dflt;
  assign ifd.sel = sel;            assign ifd.out_ready = out_ready;

  mux1h_dflt_pipe #(.WIDTH(WIDTH), .N(N), .MODE(MH_OR), .CNTW(8)) dut_or (
    .clk(clk), .rst_n(rst_n), .bus(ifo), .err_clr(err_clr), .err_sticky(sticky_o), .err_cnt(cnt_o)
  );
  mux1h_dflt_pipe #(.WIDTH(WIDTH), .N(N), .MODE(MH_PRIO), .CNTW(8)) dut_prio (
    .clk(clk), .rst_n(rst_n), .bus(ifp), .err_clr(err_clr), .err_sticky(sticky_p), .err_cnt(cnt_p)
  );
  mux1h_dflt_pipe #(.WIDTH(WIDTH), .N(N), .MODE(MH_DFLT), .CNTW(2)) dut_dflt (
    .clk(clk), .rst_n(rst_n), .bus(ifd), .err_clr(err_clr), .err_sticky(sticky_d), .err_cnt(cnt_d)
  );

  int errors = 0;
  int checks = 0;
  int snd, rcv;
  logic acc, con;
  logic [7:0] mh_sel  [5] = '{8'h03, 8'h41, 8'hFF, 8'h81, 8'h0C};
  int         sat_exp [5] = '{1, 2, 3, 3, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eo, input logic [7:0] ep,
                           input logic [7:0] ed, input logic h, input logic m);
    check({tag, "_valid"}, 32'(ifo.out_valid & ifp.out_valid & ifd.out_valid), 32'd1);
    check({tag, "_data_or"},   32'(ifo.out_data), 32'(eo));
    check({tag, "_data_prio"}, 32'(ifp.out_data), 32'(ep));
    check({tag, "_data_dflt"}, 32'(ifd.out_data), 32'(ed));
    check({tag, "_hit"},   32'({ifo.out_hit, ifp.out_hit, ifd.out_hit}),       32'(h ? 3'b111 : 3'b000));
    check({tag, "_multi"}, 32'({ifo.out_multi, ifp.out_multi, ifd.out_multi}), 32'(m ? 3'b111 : 3'b000));
  endtask

  // One transaction accepted at the next edge; returns at the following negedge.
  task automatic xfer(input logic [N-1:0] s, input logic clr);
    sel = s;
    err_clr = clr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = 8'(8'h10 + k);
    dflt = 8'hEE;

    #12;
    check("rst_in_ready",  32'(ifo.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifo.out_valid | ifp.out_valid | ifd.out_valid), 32'd0);
    check("rst_out_data",  32'(ifo.out_data), 32'd0);
    check("rst_hit_multi", 32'({ifo.out_hit, ifo.out_multi}), 32'd0);
    check("rst_err",       32'({sticky_o, cnt_o, sticky_d, cnt_d}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(8'h04, 1'b0);
    check_all("single4", 8'h12, 8'h12, 8'h12, 1'b1, 1'b0);
    check("single4_errcnt", 32'({sticky_o, cnt_o}), 32'd0);

    xfer(8'h00, 1'b0);
    check_all("zero", 8'hEE, 8'hEE, 8'hEE, 1'b0, 1'b0);

    xfer(8'h41, 1'b0);
    check_all("mh41", 8'h16, 8'h10, 8'hEE, 1'b1, 1'b1);
    check("mh41_sticky", 32'({sticky_o, sticky_p, sticky_d}), 32'b111);
    check("mh41_cnt_o", 32'(cnt_o), 32'd1);
    check("mh41_cnt_d", 32'(cnt_d), 32'd1);

    xfer(8'h18, 1'b0);
    check_all("mh18", 8'h17, 8'h13, 8'hEE, 1'b1, 1'b1);
    check("mh18_cnt_p", 32'(cnt_p), 32'd2);

    xfer(8'h80, 1'b0);
    check_all("single7", 8'h17, 8'h17, 8'h17, 1'b1, 1'b0);
    check("single7_cnt_o", 32'(cnt_o), 32'd2);

    xfer(8'h01, 1'b0);
    check_all("single0", 8'h10, 8'h10, 8'h10, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_out_valid", 32'(ifo.out_valid), 32'd0);

    // Error counter: clear, saturate the 2-bit counter, clear, clear+multi-hot.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_d", 32'({sticky_d, cnt_d}), 32'd0);
    check("clr_o", 32'({sticky_o, cnt_o}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      xfer(mh_sel[i], 1'b0);
      check($sformatf("sat%0d_cnt_d", i), 32'(cnt_d), 32'(sat_exp[i]));
      check($sformatf("sat%0d_cnt_o", i), 32'(cnt_o), 32'(i + 1));
    end
    check("sat_sticky_d", 32'(sticky_d), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr2_d", 32'({sticky_d, cnt_d}), 32'd0);
    xfer(8'h05, 1'b1);
    check("clrmh_d", 32'({sticky_d, cnt_d}), 32'b101);
    check("clrmh_o", 32'(cnt_o), 32'd1);
    xfer(8'h02, 1'b0);
    check("nomh_cnt_o", 32'(cnt_o), 32'd1);
    check_all("single1", 8'h11, 8'h11, 8'h11, 1'b1, 1'b0);

    // Back-to-back stream with out_ready low in cycles 3..6.
    sel = '0;
    snd = 0;
    rcv = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && rcv < 10; c++) begin
      in_valid  = (snd < 10);
      dflt      = 8'(8'hA0 + snd);
      out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      check($sformatf("stream_c%0d_in_ready", c), 32'(ifo.in_ready), 32'(!(c >= 4 && c <= 7)));
      if (ifo.out_valid) check($sformatf("stream_c%0d_data", c), 32'(ifo.out_data), 32'(8'(8'hA0 + rcv)));
      acc = in_valid && ifo.in_ready;
      con = ifo.out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) snd++;
      if (con) rcv++;
    end
    in_valid = 1'b0;
    check("stream_sent", 32'(snd), 32'd10);
    check("stream_recv", 32'(rcv), 32'd10);

    // Fill OR and SK, then reset mid-operation.
    out_ready = 1'b0;
    dflt = 8'hEE;
    sel = 8'h08;
    in_valid = 1'b1;
    @(posedge clk); #1;
    sel = 8'h10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", 32'(ifo.in_ready), 32'd0);
    check("full_data", 32'(ifo.out_data), 32'h13);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(ifo.out_valid | ifp.out_valid | ifd.out_valid), 32'd0);
    check("arst_out_data", 32'(ifo.out_data), 32'd0);
    check("arst_in_ready", 32'(ifo.in_ready), 32'd1);
    check("arst_err", 32'({sticky_o, cnt_o}), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_out_valid", i), 32'(ifo.out_valid), 32'd0);
    end
    xfer(8'h20, 1'b0);
    check_all("post_rst_single5", 8'h15, 8'h15, 8'h15, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
